// File: rtl/ram_arbiter_if.sv
// Fetch, load/store and shared-RAM signal bundle around ram_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the RAM.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [31:0]           if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [1:0]            ls_size;
  logic                  ls_unsigned;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [31:0]           ls_wdata;
  logic                  ls_ack;
  logic                  ls_err;
  logic [31:0]           ls_rdata;

  logic                  ram_read;
  logic                  ram_write;
  logic [1:0]            ram_data_size;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [31:0]           ram_wdata;
  logic                  ram_wdata_en;
  logic [31:0]           ram_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
    output ls_ack, ls_err, ls_rdata,
    output ram_read, ram_write, ram_data_size, ram_address, ram_wdata, ram_wdata_en,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
    input  ls_ack, ls_err, ls_rdata,
    input  ram_read, ram_write, ram_data_size, ram_address, ram_wdata, ram_wdata_en,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM between fetch and load/store ports.
// Request seen at edge N -> RAM access in cycle N+1 -> ack in N+2; rejected LS acks in N+1; req held until ack.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic          clock,
  input  logic          reset_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  last_grant_ls;
  logic                  cur_ls;
  logic                  cur_err;
  logic                  lat_we;
  logic                  lat_uns;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic [1:0]            ram_data_size_q;
  logic [31:0]           ram_wdata_q;
  logic [31:0]           if_rdata_q;
  logic [31:0]           ls_rdata_q;

  logic                  ls_bad;
  logic                  grant_ls;
  logic                  grant_if;
  logic [31:0]           load_ext;

  // Misaligned or illegal-size LS requests never reach the RAM.
  assign ls_bad = (bus.ls_size == 2'b10) ||
                  (bus.ls_size == 2'b01 && bus.ls_addr[0]) ||
                  (bus.ls_size == 2'b11 && bus.ls_addr[1:0] != 2'b00);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    grant_ls         = 1'b0;
    grant_if         = 1'b0;
    bus.ram_read     = 1'b0;
    bus.ram_write    = 1'b0;
    bus.ram_wdata_en = 1'b0;
    bus.if_ack       = 1'b0;
    bus.ls_ack       = 1'b0;
    bus.ls_err       = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        grant_ls = bus.ls_req && (!bus.if_req || !last_grant_ls);
        grant_if = bus.if_req && !grant_ls;
        if (grant_ls) begin
          state_nxt = ls_bad ? RESP : ACCESS;
        end else if (grant_if) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        bus.ram_read     = !lat_we;
        bus.ram_write    = lat_we;
        bus.ram_wdata_en = lat_we;
        state_nxt        = RESP;
      end
      RESP: begin
        bus.if_ack = !cur_ls;
        bus.ls_ack = cur_ls;
        bus.ls_err = cur_ls && cur_err;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ext = bus.ram_rdata;
    case (ram_data_size_q)
      2'b00:   load_ext = {{24{!lat_uns & bus.ram_rdata[7]}}, bus.ram_rdata[7:0]};
      2'b01:   load_ext = {{16{!lat_uns & bus.ram_rdata[15]}}, bus.ram_rdata[15:0]};
      default: load_ext = bus.ram_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_ls   <= 1'b1;
      cur_ls          <= 1'b0;
      cur_err         <= 1'b0;
      lat_we          <= 1'b0;
      lat_uns         <= 1'b0;
      ram_address_q   <= '0;
      ram_data_size_q <= 2'b00;
      ram_wdata_q     <= '0;
      if_rdata_q      <= '0;
      ls_rdata_q      <= '0;
    end else begin
      if (grant_ls) begin
        last_grant_ls <= 1'b1;
        cur_ls        <= 1'b1;
        cur_err       <= ls_bad;
        if (ls_bad) begin
          ls_rdata_q <= '0;
        end else begin
          lat_we          <= bus.ls_we;
          lat_uns         <= bus.ls_unsigned;
          ram_address_q   <= bus.ls_addr;
          ram_data_size_q <= bus.ls_size;
          ram_wdata_q     <= bus.ls_wdata;
        end
      end else if (grant_if) begin
        last_grant_ls   <= 1'b0;
        cur_ls          <= 1'b0;
        cur_err         <= 1'b0;
        lat_we          <= 1'b0;
        lat_uns         <= 1'b1;
        ram_address_q   <= bus.if_addr;
        ram_data_size_q <= 2'b11;
      end
      // Read data is captured at the edge that closes ACCESS.
      if (state == ACCESS) begin
        if (!cur_ls) begin
          if_rdata_q <= bus.ram_rdata;
        end else if (!lat_we) begin
          ls_rdata_q <= load_ext;
        end
      end
    end
  end

  assign bus.ram_address   = ram_address_q;
  assign bus.ram_data_size = ram_data_size_q;
  assign bus.ram_wdata     = ram_wdata_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.ls_rdata      = ls_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: byte-array RAM, directed vectors, arbitration and reset sequences,
// then random traffic scored against a byte-level memory model.
module tb_ram_arbiter;

  logic clock;
  logic reset_n;

  ram_arbiter_if #(.ADDR_WIDTH(12)) bus ();

  ram_arbiter #(.ADDR_WIDTH(12)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM seen by the DUT
  logic [7:0] mem [0:4095];
  bit         ram_init = 1'b0;
  wire [11:0] ra0 = bus.ram_address;
  wire [11:0] ra1 = ra0 + 12'd1;
  wire [11:0] ra2 = ra0 + 12'd2;
  wire [11:0] ra3 = ra0 + 12'd3;
  assign bus.ram_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};

  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[16] <= 8'h78; mem[17] <= 8'h56; mem[18] <= 8'h34; mem[19] <= 8'h12;
      ram_init <= 1'b1;
    end else if (bus.ram_write) begin
      mem[ra0] <= bus.ram_wdata[7:0];
      if (bus.ram_data_size != 2'b00) mem[ra1] <= bus.ram_wdata[15:8];
      if (bus.ram_data_size == 2'b11) begin
        mem[ra2] <= bus.ram_wdata[23:16];
        mem[ra3] <= bus.ram_wdata[31:24];
      end
    end
  end

  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(negedge clock) begin
    if (bus.ram_read)  rd_cnt <= rd_cnt + 1;
    if (bus.ram_write) wr_cnt <= wr_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain byte array
  logic [7:0] gm [0:4095];

  function automatic int nbytes_of(input logic [1:0] size);
    case (size)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_err(input logic [1:0] size, input logic [11:0] addr);
    int n = nbytes_of(size);
    return (n == 0) || (int'(addr) % n != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [11:0] addr, input logic [1:0] size, input bit uns);
    int     n = nbytes_of(size);
    longint v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(gm[(int'(addr) + k) % 4096]) << (8 * k));
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic void model_store(input logic [11:0] addr, input logic [1:0] size, input logic [31:0] wd);
    for (int k = 0; k < nbytes_of(size); k++) gm[(int'(addr) + k) % 4096] = 8'(wd >> (8 * k));
  endfunction

  task automatic do_op(input bit is_if, input bit we, input logic [1:0] size, input bit uns,
                       input logic [11:0] addr, input logic [31:0] wd,
                       output bit got, output bit err, output logic [31:0] rd,
                       output int cyc, output int rds, output int wrs);
    int r0, w0;
    @(posedge clock); #1;
    r0 = rd_cnt; w0 = wr_cnt;
    got = 1'b0; err = 1'b0; rd = '0; cyc = 0;
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_size = size;
      bus.ls_unsigned = uns; bus.ls_addr = addr; bus.ls_wdata = wd;
    end
    while (!got && cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
      if (is_if && bus.if_ack) begin
        got = 1'b1; rd = bus.if_rdata;
      end else if (!is_if && bus.ls_ack) begin
        got = 1'b1; err = bus.ls_err; rd = bus.ls_rdata;
      end
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    rds = rd_cnt - r0;
    wrs = wr_cnt - w0;
  endtask

  task automatic check_op(input string tag, input bit is_if, input bit we, input logic [1:0] size,
                          input bit uns, input logic [11:0] addr, input logic [31:0] wd,
                          input bit exp_err, input logic [31:0] exp_rd, input bit chk_rd);
    bit got, err;
    logic [31:0] rd;
    int cyc, rds, wrs;
    do_op(is_if, we, size, uns, addr, wd, got, err, rd, cyc, rds, wrs);
    chk({tag, " ack"}, got, 1);
    chk({tag, " err"}, err, exp_err);
    chk({tag, " latency"}, cyc, exp_err ? 1 : 2);
    chk({tag, " reads"}, rds, (!exp_err && (is_if || !we)) ? 1 : 0);
    chk({tag, " writes"}, wrs, (!exp_err && !is_if && we) ? 1 : 0);
    if (chk_rd) chk({tag, " rdata"}, rd, exp_rd);
  endtask

  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] wd;
    bit          exp_err;
    logic [31:0] exp_rd;
    bit          chk_rd;
  } vec_t;

  vec_t vt [15];

  initial begin
    vt[0]  = '{1'b0, 1'b1, 2'b11, 1'b0, 12'h020, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 12'h023, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 2'b00, 1'b1, 12'h023, 32'h0,        1'b0, 32'h000000DE, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 2'b01, 1'b0, 12'h021, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[4]  = '{1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 12'h030, 32'hAAAA5555, 1'b0, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 1'b0, 2'b11, 1'b0, 12'h030, 32'h0,        1'b0, 32'h00005555, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 2'b11, 1'b0, 12'h010, 32'h0,        1'b0, 32'h12345678, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 2'b01, 1'b0, 12'h022, 32'h0,        1'b0, 32'hFFFFDEAD, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 2'b01, 1'b1, 12'h022, 32'h0,        1'b0, 32'h0000DEAD, 1'b1};
    vt[10] = '{1'b0, 1'b0, 2'b11, 1'b0, 12'h020, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
    vt[11] = '{1'b0, 1'b0, 2'b11, 1'b0, 12'h022, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[12] = '{1'b0, 1'b0, 2'b00, 1'b0, 12'h020, 32'h0,        1'b0, 32'hFFFFFFEF, 1'b1};
    vt[13] = '{1'b0, 1'b1, 2'b00, 1'b0, 12'h033, 32'h12345699, 1'b0, 32'h0,        1'b0};
    vt[14] = '{1'b0, 1'b0, 2'b11, 1'b0, 12'h030, 32'h0,        1'b0, 32'h99005555, 1'b1};

    for (int i = 0; i < 4096; i++) gm[i] = 8'h00;
    gm[16] = 8'h78; gm[17] = 8'h56; gm[18] = 8'h34; gm[19] = 8'h12;

    reset_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'b00;
    bus.ls_unsigned = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset strobes/acks",
        {bus.if_ack, bus.ls_ack, bus.ls_err, bus.ram_read, bus.ram_write, bus.ram_wdata_en}, 0);
    chk("reset ram addr/size", {bus.ram_address, bus.ram_data_size}, 0);
    chk("reset ram_wdata", bus.ram_wdata, 0);
    chk("reset rdata", {bus.if_rdata, bus.ls_rdata}, 0);
    #4 reset_n = 1'b1;

    // Both ports held: first tie after reset goes to IF, then strict alternation
    begin
      int order[$];
      int stamp[$];
      int cyc;
      @(posedge clock); #1;
      bus.if_req = 1'b1; bus.if_addr = 12'h010;
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b11;
      bus.ls_unsigned = 1'b0; bus.ls_addr = 12'h010;
      cyc = 0;
      while (order.size() < 4 && cyc < 40) begin
        @(posedge clock); #1;
        cyc++;
        if (bus.if_ack) begin
          order.push_back(0); stamp.push_back(cyc);
          chk("tie if_rdata", bus.if_rdata, 32'h12345678);
        end
        if (bus.ls_ack) begin
          order.push_back(1); stamp.push_back(cyc);
          chk("tie ls_rdata", bus.ls_rdata, 32'h12345678);
        end
      end
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      chk("tie ack count", order.size(), 4);
      if (order.size() > 0) chk("tie first ack cycle", stamp[0], 2);
      for (int k = 0; k < order.size(); k++) begin
        chk($sformatf("tie grant %0d", k), order[k], k % 2);
        if (k > 0) chk($sformatf("tie spacing %0d", k), stamp[k] - stamp[k - 1], 3);
      end
    end

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      check_op($sformatf("v%0d", i), vt[i].is_if, vt[i].we, vt[i].size, vt[i].uns,
               vt[i].addr, vt[i].wd, vt[i].exp_err, vt[i].exp_rd, vt[i].chk_rd);
      if (!vt[i].is_if && vt[i].we) model_store(vt[i].addr, vt[i].size, vt[i].wd);
    end
    chk("if_rdata held across LS traffic", bus.if_rdata, 32'h12345678);

    // Reset during the ACCESS of a store
    begin
      int acks;
      @(posedge clock); #1;
      bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b11;
      bus.ls_unsigned = 1'b0; bus.ls_addr = 12'h040; bus.ls_wdata = 32'hCAFEF00D;
      @(posedge clock); #1;
      chk("rst-store write in ACCESS", bus.ram_write, 1);
      #1;
      reset_n = 1'b0;
      bus.ls_req = 1'b0;
      #1;
      chk("rst-store write dropped", {bus.ram_write, bus.ram_wdata_en}, 0);
      chk("rst-store outputs cleared", {bus.ram_address, bus.ls_rdata, bus.if_rdata}, 0);
      #3 reset_n = 1'b1;
      acks = 0;
      repeat (4) begin
        @(posedge clock); #1;
        if (bus.ls_ack) acks++;
      end
      chk("rst-store no ack", acks, 0);
      check_op("rst-store readback", 1'b0, 1'b0, 2'b11, 1'b0, 12'h040, 32'h0, 1'b0, 32'h0, 1'b1);
    end

    // Random traffic against the byte model
    for (int n = 0; n < 300; n++) begin
      bit          is_if, we, uns, e;
      logic [1:0]  size;
      logic [11:0] addr;
      logic [31:0] wd, exp_rd;
      is_if = ($urandom_range(0, 3) == 0);
      we    = $urandom_range(0, 1);
      uns   = $urandom_range(0, 1);
      size  = 2'($urandom_range(0, 3));
      addr  = 12'($urandom_range(0, 255));
      wd    = $urandom;
      if (is_if) begin
        addr = {addr[11:2], 2'b00};
        check_op($sformatf("rnd%0d if", n), 1'b1, 1'b0, 2'b11, 1'b0, addr, 32'h0,
                 1'b0, model_load(addr, 2'b11, 1'b1), 1'b1);
      end else begin
        if ($urandom_range(0, 1) == 1) addr = {addr[11:2], 2'b00};
        e = model_err(size, addr);
        exp_rd = (e || we) ? 32'h0 : model_load(addr, size, uns);
        check_op($sformatf("rnd%0d ls", n), 1'b0, we, size, uns, addr, wd, e, exp_rd, e || !we);
        if (!e && we) model_store(addr, size, wd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
